// File: rtl/usb_pkg.sv
// Shared USB definitions: packet type encoding, PID bytes and CRC16 constants.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_packet_t;

  localparam logic [7:0]  PID_DATA0       = 8'hC3;
  localparam logic [7:0]  PID_DATA1       = 8'h4B;
  localparam logic [7:0]  PID_ACK         = 8'hD2;
  localparam logic [7:0]  PID_NAK         = 8'h5A;
  localparam logic [7:0]  PID_STALL       = 8'h1E;

  localparam logic [7:0]  SYNC_BYTE       = 8'h80;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [6:0]  MAX_LEN         = 7'd64;

  // PID byte that goes on the wire for each packet type
  function automatic logic [7:0] pid_byte(input tx_packet_t pkt);
    case (pkt)
      PKT_DATA0: pid_byte = PID_DATA0;
      PKT_DATA1: pid_byte = PID_DATA1;
      PKT_ACK:   pid_byte = PID_ACK;
      PKT_NAK:   pid_byte = PID_NAK;
      PKT_STALL: pid_byte = PID_STALL;
      default:   pid_byte = 8'h00;
    endcase
  endfunction

  // Packet types that carry a payload and a CRC16
  function automatic logic is_data_packet(input tx_packet_t pkt);
    is_data_packet = (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
  endfunction

  // Packet types this sequencer knows how to send
  function automatic logic is_known_packet(input tx_packet_t pkt);
    is_known_packet = (pkt == PKT_DATA0) || (pkt == PKT_DATA1) || (pkt == PKT_ACK) ||
                      (pkt == PKT_NAK) || (pkt == PKT_STALL);
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the USB CRC16 (reflected polynomial, LSB-first bit order).
module usb_crc16_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  import usb_pkg::*;

  // Shift the eight data bits through the reflected polynomial, LSB first
  always_comb begin
    logic [15:0] work;
    work = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (work[0] ^ data[i]) begin
        work = (work >> 1) ^ CRC16_POLY_REFL;
      end else begin
        work = work >> 1;
      end
    end
    crc_out = work;
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Byte-level USB transmit sequencer: SYNC, PID, payload pulled from the
// data buffer, then CRC16, handed to the bit encoder over valid/ready.
module usb_tx_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] tx_length,
  input  logic       tx_abort,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       clear,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  input  logic       tx_byte_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  import usb_pkg::*;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_FETCH,
    ST_LOAD,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } state_t;

  state_t     state;
  tx_packet_t pkt_type;
  tx_packet_t req_type;
  logic [6:0] remaining;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic       length_bad;
  logic       transfer;

  assign req_type   = tx_packet_t'(tx_packet);
  assign length_bad = (tx_length > MAX_LEN) || (tx_length > buffer_occupancy);
  assign transfer   = tx_byte_valid && tx_byte_ready;

  usb_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (tx_byte),
    .crc_out (crc_next)
  );

  // Packet sequencing FSM; every output is registered and set for the state being entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= ST_IDLE;
      pkt_type           <= PKT_NONE;
      remaining          <= 7'd0;
      crc                <= CRC16_INIT;
      get_tx_packet_data <= 1'b0;
      clear              <= 1'b0;
      tx_byte            <= 8'h00;
      tx_byte_valid      <= 1'b0;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      get_tx_packet_data <= 1'b0;
      clear              <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
      if (tx_abort && (state != ST_IDLE)) begin
        state         <= ST_IDLE;
        tx_byte       <= 8'h00;
        tx_byte_valid <= 1'b0;
        tx_busy       <= 1'b0;
        clear         <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_start) begin
              if (is_data_packet(req_type) && length_bad) begin
                tx_error <= 1'b1;
              end else if (is_known_packet(req_type)) begin
                state         <= ST_SYNC;
                pkt_type      <= req_type;
                remaining     <= is_data_packet(req_type) ? tx_length : 7'd0;
                crc           <= CRC16_INIT;
                tx_byte       <= SYNC_BYTE;
                tx_byte_valid <= 1'b1;
                tx_busy       <= 1'b1;
              end
            end
          end
          ST_SYNC: begin
            if (transfer) begin
              state   <= ST_PID;
              tx_byte <= pid_byte(pkt_type);
            end
          end
          ST_PID: begin
            if (transfer) begin
              if (!is_data_packet(pkt_type)) begin
                state         <= ST_DONE;
                tx_byte       <= 8'h00;
                tx_byte_valid <= 1'b0;
                tx_done       <= 1'b1;
              end else if (remaining != 7'd0) begin
                state              <= ST_FETCH;
                tx_byte_valid      <= 1'b0;
                get_tx_packet_data <= 1'b1;
              end else begin
                state   <= ST_CRC_LO;
                tx_byte <= ~crc[7:0];
              end
            end
          end
          ST_FETCH: begin
            state <= ST_LOAD;
          end
          ST_LOAD: begin
            state         <= ST_DATA;
            tx_byte       <= tx_packet_data;
            tx_byte_valid <= 1'b1;
          end
          ST_DATA: begin
            if (transfer) begin
              crc       <= crc_next;
              remaining <= remaining - 7'd1;
              if (remaining != 7'd1) begin
                state              <= ST_FETCH;
                tx_byte_valid      <= 1'b0;
                get_tx_packet_data <= 1'b1;
              end else begin
                state   <= ST_CRC_LO;
                tx_byte <= ~crc_next[7:0];
              end
            end
          end
          ST_CRC_LO: begin
            if (transfer) begin
              state   <= ST_CRC_HI;
              tx_byte <= ~crc[15:8];
            end
          end
          ST_CRC_HI: begin
            if (transfer) begin
              state         <= ST_DONE;
              tx_byte       <= 8'h00;
              tx_byte_valid <= 1'b0;
              tx_done       <= 1'b1;
            end
          end
          ST_DONE: begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end
          default: begin
            state         <= ST_IDLE;
            tx_byte_valid <= 1'b0;
            tx_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
- Byte-level transmit sequencer for the USB endpoint.
- On a start request from the protocol controller, it emits SYNC, then PID, then (for data packets) payload bytes drained from the 64-byte data_buffer, then CRC16.
- Bytes are handed to the bit-level TX encoder over a valid/ready handshake.
- It is the only block that drives data_buffer's get_tx_packet_data and clear.

Parameters:
- MAX_LEN, 64, maximum payload bytes per packet; equals data_buffer depth.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- tx_start  in  1  one-cycle start request; sampled only in IDLE
- tx_packet  in  3  packet type, sampled with tx_start: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL
- tx_length  in  7  payload byte count for DATA0/DATA1, 0..64, sampled with tx_start
- tx_abort  in  1  abandon packet; takes priority over everything except reset
- buffer_occupancy  in  7  current data_buffer fill level
- tx_packet_data  in  8  data_buffer read data; valid the cycle after a get pulse
- get_tx_packet_data  out  1  one-cycle pop strobe to data_buffer
- clear  out  1  one-cycle flush strobe to data_buffer
- tx_byte  out  8  byte to encoder, sent LSB-first by the encoder
- tx_byte_valid  out  1  tx_byte is valid
- tx_byte_ready  in  1  encoder accepts tx_byte at this rising edge
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse after the last byte is accepted
- tx_error  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset value of every output is 0. State resets to IDLE. The CRC register resets to 0xFFFF.
- States: IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, DONE.
- IDLE, on tx_start:
  - tx_packet NONE or 6/7: ignored; stay in IDLE, no pulse.
  - DATA0/DATA1 with tx_length > MAX_LEN or tx_length > buffer_occupancy: tx_error pulses the next cycle; stay in IDLE; no byte is emitted and no pop is issued.
  - Otherwise: latch type and length, set remaining count = tx_length, set CRC = 0xFFFF, go to SYNC.
- SYNC: tx_byte = 0x80, valid = 1. On ready, go to PID.
- PID: tx_byte = 0xC3 (DATA0), 0x4B (DATA1), 0xD2 (ACK), 0x5A (NAK) or 0x1E (STALL).
  - On ready, handshake types go to DONE.
  - On ready, data types go to FETCH if remaining > 0, else to CRC_LO.
- FETCH: get_tx_packet_data = 1 for exactly this cycle; valid = 0; go to LOAD.
- LOAD: capture tx_packet_data into the byte register; valid = 0; go to DATA.
- DATA: present the captured byte with valid = 1. On ready:
  - fold the byte into the CRC and decrement remaining;
  - go to FETCH if remaining (post-decrement) > 0, else to CRC_LO.
- CRC16 (USB):
  - polynomial 0x8005, processed LSB-first (reflected form 0xA001), init 0xFFFF;
  - each accepted payload byte updates the CRC combinationally over 8 bits in one cycle;
  - the transmitted value is the bitwise complement of the register.
- CRC_LO sends complement[7:0]; CRC_HI sends complement[15:8]. On ready in CRC_HI, go to DONE.
- DONE: tx_done = 1 for one cycle; go to IDLE.
- Handshake rules:
  - tx_byte and tx_byte_valid are registered, and tx_byte holds stable while valid && !ready.
  - valid never drops without a transfer, except on abort or reset.
  - A transfer is valid && ready at a rising edge.
  - ready while valid = 0 is ignored.
- Pops: exactly tx_length pops per data packet, with at most one pop in flight. Pops occur only in FETCH, never while a byte is pending.
- tx_abort in any non-IDLE state:
  - next cycle: state = IDLE, valid = 0, clear = 1 for one cycle;
  - no tx_done, no tx_error.
  - tx_abort in IDLE has no effect.
- tx_start while busy is ignored. tx_start and tx_abort together in IDLE: start wins (abort is a no-op in IDLE).
- Reset mid-packet: everything returns to reset values immediately; the buffer is not cleared by this block.
- Throughput: 3 cycles per payload byte minimum (FETCH, LOAD, DATA with ready held high).
- The remaining-count register is 7 bits and never wraps, because start checks bound it.

Decomposition:
- Shared package usb_pkg:
  - typedef of the tx_packet encoding;
  - PID constants: PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL;
  - SYNC_BYTE = 0x80, CRC16_INIT = 0xFFFF, CRC16_POLY_REFL = 0xA001, MAX_LEN = 64.
- One sub-module: usb_crc16_byte, purely combinational (crc_in[15:0], data[7:0] -> crc_out[15:0]). It is reusable by the RX checker.

Test Plan:
- ACK start, ready held high -> bytes 0x80, 0xD2 accepted on consecutive transfers; tx_done pulses once; zero get pulses; tx_busy low afterward.
- DATA0, tx_length = 0, occupancy 0 -> bytes 0x80, 0xC3, 0x00, 0x00 (ZLP CRC); zero pops; tx_done.
- Pre-fill data_buffer with 0x00..0x3F (64 bytes), DATA1, tx_length = 64, random ready stalls:
  - bytes 0x80, 0x4B, 0x00..0x3F in order, then the 2 CRC bytes matching a software model;
  - exactly 64 get pulses; occupancy ends at 0;
  - tx_byte stable across every stall.
- Occupancy 3, DATA0 with tx_length = 4 -> tx_error pulse one cycle later; no valid, no pop; state stays IDLE. Repeat with tx_length = 65 -> same result.
- Start DATA0, tx_length = 10; assert tx_abort after the 4th payload transfer -> valid low next cycle; clear pulses once; no tx_done; a following ACK start transmits normally.
- Assert n_rst mid-DATA -> all outputs 0 asynchronously; after release, a NAK packet emits 0x80, 0x5A.
